// File: rtl/bcd_display_scanner_if.sv
// Conversion request/status and digit-scan bus between the ALU side and bcd_display_scanner.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [15:0]           value_in;
  logic                  load;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [3:0]            digit_bin;
  logic [NUM_DIGITS-1:0] an;

  modport master (output value_in, load,
                  input  busy, done, overflow, digit_bin, an);
  modport slave  (input  value_in, load,
                  output busy, done, overflow, digit_bin, an);
endinterface

// File: rtl/bcd_display_scanner.sv
// Sequential double-dabble binary->BCD converter feeding a multiplexed digit scanner.
// Optional: define LEADING_ZERO_BLANK_EN to blank most-significant zero digits at latch time.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               rst_n,
  bcd_display_scanner_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [1:0]                 r_state;
  logic [15:0]                r_bin;
  logic [19:0]                r_bcd;
  logic [3:0]                 r_cnt;
  logic                       r_busy, r_done, r_ovf;
  logic [NUM_DIGITS-1:0][3:0] r_dig;
  logic [PW-1:0]              r_pre;
  logic [IW-1:0]              r_idx;
  logic [NUM_DIGITS-1:0]      r_an;
  logic [3:0]                 r_dbin;

  logic [18:0]                w_adj;
  logic                       w_ovf;
  logic [NUM_DIGITS-1:0][3:0] w_dig;
  logic                       w_wrap;
  logic [IW-1:0]              w_nidx;

  // Add-3 correction on the four low nibbles. The ten-thousands nibble holds at most 3
  // before the final shift of a 16-bit input, so it never needs correcting.
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                        : r_bcd[4*g +: 4];
  end
  assign w_adj[18:16] = r_bcd[18:16];

  assign w_ovf = (NUM_DIGITS == 4) && (r_bcd[19:16] != 4'd0);

`ifdef LEADING_ZERO_BLANK_EN
  logic w_lead;
  always_comb begin
    w_dig  = r_bcd[4*NUM_DIGITS-1:0];
    w_lead = 1'b1;
    if (w_ovf) w_dig = {NUM_DIGITS{4'hF}};
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      if (w_lead && w_dig[i] == 4'd0) w_dig[i] = 4'hF;
      else                            w_lead   = 1'b0;
    end
  end
`else
  always_comb begin
    w_dig = r_bcd[4*NUM_DIGITS-1:0];
    if (w_ovf) w_dig = {NUM_DIGITS{4'hF}};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dig   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.load) begin
          r_bin   <= bus.value_in;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_bcd <= {w_adj, r_bin[15]};
          r_bin <= {r_bin[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_dig   <= w_dig;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scanner free-runs; fresh digits appear only at the next slot boundary.
  assign w_wrap = (r_pre == PW'(REFRESH_DIV-1));
  assign w_nidx = (r_idx == IW'(NUM_DIGITS-1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_an   <= ~NUM_DIGITS'(1);
      r_dbin <= '0;
    end else if (w_wrap) begin
      r_pre  <= '0;
      r_idx  <= w_nidx;
      r_an   <= ~(NUM_DIGITS'(1) << w_nidx);
      r_dbin <= r_dig[w_nidx];
    end else begin
      r_pre  <= r_pre + 1'b1;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overflow  = r_ovf;
  assign bus.digit_bin = r_dbin;
  assign bus.an        = r_an;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed + random bench for bcd_display_scanner; expected digits come from decimal arithmetic.
module tb_bcd_display_scanner;
  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(N)) bus();
  bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*4-1:0] model(input int v);
    logic [N*4-1:0] d;
    int x;
    x = v;
    if (N == 4 && v > 9999) return {N{4'hF}};
    for (int i = 0; i < N; i++) begin
      d[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = N-1; i > 0; i--) begin
      if (d[4*i +: 4] != 4'd0) break;
      d[4*i +: 4] = 4'hF;
    end
`endif
    return d;
  endfunction

  // Pulse load for one edge, then wait (bounded) for done; report latency and busy cycles.
  task automatic convert(input int v, output int lat, output int bcnt);
    bus.value_in = 16'(v);
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    lat  = 0;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (bus.busy === 1'b1) bcnt++;
    end
  endtask

  task automatic scan_chk(input string tag, input logic [N*4-1:0] e);
    int idx;
    logic [N-1:0] ea;
    repeat (R) tick();
    for (int c = 0; c < N*R; c++) begin
      idx = (cyc / R) % N;
      ea  = ~(N'(1) << idx);
      chk({tag, "_an"}, 32'(bus.an), 32'(ea));
      chk({tag, "_dig"}, 32'(bus.digit_bin), 32'(e[4*idx +: 4]));
      tick();
    end
  endtask

  task automatic full(input string tag, input int v);
    int lat, bcnt;
    convert(v, lat, bcnt);
    chk({tag, "_lat"}, 32'(lat), 32'd17);
    chk({tag, "_busy"}, 32'(bcnt), 32'd17);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'((N == 4 && v > 9999) ? 1 : 0));
    tick();
    chk({tag, "_done_end"}, 32'(bus.done), 32'd0);
    scan_chk(tag, model(v));
  endtask

  initial begin
    int ndone, v, lat, bcnt;
    bus.value_in = '0;
    bus.load     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    chk("rst_an",   32'(bus.an), 32'(4'b1110));
    chk("rst_dig",  32'(bus.digit_bin), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);

    full("v1234", 1234);
    full("v65535", 65535);
    full("v9999", 9999);
    full("v42", 42);
    full("v0", 0);
    full("v1005", 1005);
    full("v10000", 10000);

    // Second load arrives mid-conversion and must be dropped.
    bus.value_in = 16'd5678;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (4) tick();
    bus.value_in = 16'd1111;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    ndone = 0;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("rej_ndone", 32'(ndone), 32'd1);
    scan_chk("rej", model(5678));

    // Held load restarts right after each return to IDLE: dones at edges 17 and 35.
    bus.value_in = 16'd77;
    bus.load     = 1'b1;
    ndone = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    bus.load = 1'b0;
    chk("hold_ndone", 32'(ndone), 32'd2);
    lat = 0;
    while (bus.busy === 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("hold_idle", 32'(bus.busy), 32'd0);
    scan_chk("hold", model(77));

    for (int i = 0; i < 24; i++) begin
      v = ($urandom % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      full("rand", v);
    end

    // Reset mid-conversion wipes everything, and the aborted conversion never completes.
    bus.value_in = 16'd4321;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_ovf",  32'(bus.overflow), 32'd0);
    chk("mrst_an",   32'(bus.an), 32'(4'b1110));
    chk("mrst_dig",  32'(bus.digit_bin), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    ndone = 0;
    repeat (25) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("mrst_ndone", 32'(ndone), 32'd0);
    scan_chk("mrst", '0);

    convert(9, lat, bcnt);
    chk("post_lat", 32'(lat), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
